// File: rtl/conv_ctrl_pkg.sv
// Shared types for the 3x3 conv stream controller: FSM states, tap indices, pad-mask helper.
// Pure definitions; no timing or flow-control behaviour of its own.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  localparam int TAP_NW = 0;
  localparam int TAP_N  = 1;
  localparam int TAP_NE = 2;
  localparam int TAP_W  = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_E  = 5;
  localparam int TAP_SW = 6;
  localparam int TAP_S  = 7;
  localparam int TAP_SE = 8;

  // Center is always in-image, so a tap falls outside only at the matching border.
  function automatic logic [8:0] calc_pad_mask(input int row, input int col,
                                               input int img_w, input int img_h);
    logic top, bot, lft, rgt;
    logic [8:0] m;
    top = (row == 0);
    bot = (row == img_h - 1);
    lft = (col == 0);
    rgt = (col == img_w - 1);
    m         = '0;
    m[TAP_NW] = top | lft;
    m[TAP_N]  = top;
    m[TAP_NE] = top | rgt;
    m[TAP_W]  = lft;
    m[TAP_C]  = 1'b0;
    m[TAP_E]  = rgt;
    m[TAP_SW] = bot | lft;
    m[TAP_S]  = bot;
    m[TAP_SE] = bot | rgt;
    return m;
  endfunction

endpackage

// File: rtl/conv3x3_pos_counter.sv
// Raster row/col position counter: col wraps at IMG_W-1 and bumps row; clear wins over enable.
// Updates one cycle after en; no flow control of its own.
module conv3x3_pos_counter #(
  parameter int IMG_W = 104,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == CNT_W'(IMG_W - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv3x3_stream_ctrl.sv
// Sequences pixel load + zero flush into shared line buffers and presents each 3x3 window 1 cycle after its last shift.
// Shifts that would complete a window stall while a presented window is held by out_ready=0.
module conv3x3_stream_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_W = 104,
  parameter int IMG_H = 104,
  parameter int CNT_W = 7,
  parameter int E_W   = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  output logic             flush_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_row,
  output logic [CNT_W-1:0] out_col,
  output logic [8:0]       pad_mask,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [E_W-1:0] E_FILL     = E_W'(IMG_W + 1);
  localparam logic [E_W-1:0] E_LAST_PIX = E_W'(IMG_W * IMG_H - 1);
  localparam logic [E_W-1:0] E_LAST     = E_W'(IMG_W * IMG_H + IMG_W);

  state_t           state, state_nxt;
  logic [E_W-1:0]   e;
  logic             can_shift;
  logic             win;
  logic             done_nxt;
  logic             frame_clr;
  logic [CNT_W-1:0] pos_row, pos_col;

  // Fill shifts never complete a window, so they may proceed under backpressure.
  assign can_shift = (e < E_FILL) || !out_valid || out_ready;
  assign win       = shift_en && (e >= E_FILL);
  assign frame_clr = (state == IDLE) && start;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    shift_en   = 1'b0;
    flush_zero = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = can_shift;
        shift_en = in_valid && can_shift;
        if (shift_en && (e == E_LAST_PIX)) state_nxt = FLUSH;
      end
      FLUSH: begin
        shift_en   = can_shift;
        flush_zero = 1'b1;
        if (can_shift && (e == E_LAST)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      e          <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= done_nxt;
      if (frame_clr) e <= '0;
      else if (shift_en) e <= e + 1'b1;
    end
  end

  conv3x3_pos_counter #(
    .IMG_W(IMG_W),
    .CNT_W(CNT_W)
  ) u_pos (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (frame_clr),
    .en   (win),
    .row  (pos_row),
    .col  (pos_col)
  );

  // A new window overwrites the presented one only when it was accepted this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      pad_mask  <= '0;
    end else if (win) begin
      out_valid <= 1'b1;
      out_row   <= pos_row;
      out_col   <= pos_col;
      pad_mask  <= calc_pad_mask(int'(pos_row), int'(pos_col), IMG_W, IMG_H);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream_ctrl.sv
// Bench for conv3x3_stream_ctrl: 4x4 instance for detailed scenarios, 104x104 instance for full-size count.
module tb_conv3x3_stream_ctrl;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int BW = 104;
  localparam int BH = 104;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s_start = 0, s_in_valid = 0, s_out_ready = 0;
  logic       s_in_ready, s_shift_en, s_flush_zero, s_out_valid, s_busy, s_frame_done;
  logic [6:0] s_out_row, s_out_col;
  logic [8:0] s_pad_mask;

  logic       b_start = 0, b_in_valid = 0, b_out_ready = 0;
  logic       b_in_ready, b_shift_en, b_flush_zero, b_out_valid, b_busy, b_frame_done;
  logic [6:0] b_out_row, b_out_col;
  logic [8:0] b_pad_mask;

  conv3x3_stream_ctrl #(.IMG_W(W), .IMG_H(H), .CNT_W(7), .E_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .shift_en(s_shift_en), .flush_zero(s_flush_zero), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_row(s_out_row), .out_col(s_out_col), .pad_mask(s_pad_mask), .busy(s_busy),
    .frame_done(s_frame_done)
  );

  conv3x3_stream_ctrl #(.IMG_W(BW), .IMG_H(BH), .CNT_W(7), .E_W(14)) dut_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .shift_en(b_shift_en), .flush_zero(b_flush_zero), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_row(b_out_row), .out_col(b_out_col), .pad_mask(b_pad_mask), .busy(b_busy),
    .frame_done(b_frame_done)
  );

  int n_chk = 0;
  int n_pass = 0;

  // results of the most recent small-instance frame
  int acc_row[$], acc_col[$], acc_mask[$], acc_cyc[$], beat_cyc[$], done_cyc[$];
  int first_vld, stab_err, n_pix, n_flush, stall_low;
  int st_row, st_col, st_mask;
  bit timed_out;

  // Reference: a tap is padding iff its pixel lies outside the image.
  function automatic int model_mask(int r, int c, int w, int h);
    int m = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (r + dy < 0 || r + dy >= h || c + dx < 0 || c + dx >= w)
          m |= 1 << ((dy + 1) * 3 + (dx + 1));
    return m;
  endfunction

  // vmode: 0 continuous, 1 every other cycle, 2 random. rmode: 0 always ready, 1 10-cycle stall, 2 random.
  task automatic run_frame(input int vmode, input int rmode, input int stall_at, input bit spam);
    int cyc = 0;
    int post = -1;
    bit prev_hold = 0;
    int h_row = 0, h_col = 0, h_mask = 0;
    acc_row.delete(); acc_col.delete(); acc_mask.delete(); acc_cyc.delete();
    beat_cyc.delete(); done_cyc.delete();
    first_vld = -1; stab_err = 0; n_pix = 0; n_flush = 0; stall_low = 0;
    st_row = -1; st_col = -1; st_mask = -1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    while (cyc < 400 && (post < 0 || cyc < post + 3)) begin
      s_in_valid  = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      s_out_ready = (rmode == 0) ? 1'b1 :
                    (rmode == 1) ? !(cyc >= stall_at && cyc < stall_at + 10) :
                    ($urandom_range(0, 3) != 0);
      s_start     = spam && cyc < 14 && ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (s_in_valid && s_in_ready) beat_cyc.push_back(cyc);
      if (s_shift_en) begin
        if (s_flush_zero) n_flush++;
        else n_pix++;
      end
      if (first_vld < 0 && s_out_valid) first_vld = cyc;
      if (prev_hold && (!s_out_valid || int'(s_out_row) != h_row || int'(s_out_col) != h_col ||
                        int'(s_pad_mask) != h_mask))
        stab_err++;
      prev_hold = s_out_valid && !s_out_ready;
      h_row = int'(s_out_row); h_col = int'(s_out_col); h_mask = int'(s_pad_mask);
      if (rmode == 1 && cyc >= stall_at && cyc < stall_at + 10 && !s_in_ready) stall_low++;
      if (rmode == 1 && cyc == stall_at + 9) begin
        st_row = h_row; st_col = h_col; st_mask = h_mask;
      end
      if (s_out_valid && s_out_ready) begin
        acc_row.push_back(h_row); acc_col.push_back(h_col);
        acc_mask.push_back(h_mask); acc_cyc.push_back(cyc);
      end
      if (s_frame_done) begin
        done_cyc.push_back(cyc);
        if (post < 0) post = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    timed_out   = (post < 0);
    s_start     = 1'b0;
    s_in_valid  = 1'b0;
    s_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_chk++;
    if ({s_in_ready, s_shift_en, s_flush_zero, s_out_valid, s_busy, s_frame_done} !== 6'b0 ||
        s_out_row !== 7'd0 || s_out_col !== 7'd0 || s_pad_mask !== 9'd0)
      $display("FAIL reset_outputs: got rdy=%b sh=%b fz=%b ov=%b busy=%b fd=%b row=%0d col=%0d mask=%h, want all 0",
               s_in_ready, s_shift_en, s_flush_zero, s_out_valid, s_busy, s_frame_done,
               s_out_row, s_out_col, s_pad_mask);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (s_busy !== 1'b0 || s_in_ready !== 1'b0)
      $display("FAIL idle_after_reset: busy=%b in_ready=%b, want 0 0", s_busy, s_in_ready);
    else n_pass++;
  endtask

  task automatic test_continuous;
    run_frame(0, 0, 0, 0);
    n_chk++;
    if (timed_out) $display("FAIL cont_timeout: no frame_done within 400 cycles");
    else n_pass++;
    n_chk++;
    if (beat_cyc.size() < 6 || first_vld != beat_cyc[5] + 1)
      $display("FAIL first_latency: first out_valid cycle %0d, want beat5 cycle+1 (%0d beats)",
               first_vld, beat_cyc.size());
    else n_pass++;
    n_chk++;
    if (acc_row.size() < 1 || acc_row[0] != 0 || acc_col[0] != 0 || acc_mask[0] != 'h04F)
      $display("FAIL first_window: got (%0d,%0d) mask %h, want (0,0) mask 04f",
               acc_row.size() ? acc_row[0] : -1, acc_col.size() ? acc_col[0] : -1,
               acc_mask.size() ? acc_mask[0] : -1);
    else n_pass++;
    n_chk++;
    if (acc_row.size() != N) $display("FAIL cont_count: got %0d windows, want %0d", acc_row.size(), N);
    else n_pass++;
    for (int i = 0; i < acc_row.size() && i < N; i++) begin
      n_chk++;
      if (acc_row[i] != i / W || acc_col[i] != i % W || acc_mask[i] != model_mask(i / W, i % W, W, H))
        $display("FAIL cont_win%0d: got (%0d,%0d) mask %h, want (%0d,%0d) mask %h", i,
                 acc_row[i], acc_col[i], acc_mask[i], i / W, i % W, model_mask(i / W, i % W, W, H));
      else n_pass++;
    end
    n_chk++;
    if (done_cyc.size() != 1 || acc_cyc.size() != N || done_cyc[0] != acc_cyc[N-1] + 1)
      $display("FAIL done_timing: %0d pulses, first at %0d, want 1 pulse at last accept+1 (%0d)",
               done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1,
               acc_cyc.size() ? acc_cyc[acc_cyc.size()-1] + 1 : -1);
    else n_pass++;
    n_chk++;
    if (n_pix != N || n_flush != W + 1)
      $display("FAIL shift_counts: pixel shifts %0d flush shifts %0d, want %0d %0d", n_pix, n_flush, N, W + 1);
    else n_pass++;
    n_chk++;
    if (acc_mask.size() != N || acc_mask[11] != 'h124 || acc_mask[12] != 'h1C9)
      $display("FAIL border_masks: (2,3)=%h (3,0)=%h, want 124 1c9",
               acc_mask.size() > 11 ? acc_mask[11] : -1, acc_mask.size() > 12 ? acc_mask[12] : -1);
    else n_pass++;
  endtask

  task automatic test_toggle;
    run_frame(1, 0, 0, 0);
    n_chk++;
    if (acc_row.size() != N || done_cyc.size() != 1 || beat_cyc.size() != N)
      $display("FAIL toggle_counts: windows %0d done %0d beats %0d, want %0d 1 %0d",
               acc_row.size(), done_cyc.size(), beat_cyc.size(), N, N);
    else n_pass++;
    for (int i = 0; i < acc_row.size() && i < N; i++) begin
      n_chk++;
      if (acc_row[i] != i / W || acc_col[i] != i % W || acc_mask[i] != model_mask(i / W, i % W, W, H))
        $display("FAIL toggle_win%0d: got (%0d,%0d) mask %h, want (%0d,%0d) mask %h", i,
                 acc_row[i], acc_col[i], acc_mask[i], i / W, i % W, model_mask(i / W, i % W, W, H));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    int q;
    run_frame(0, 1, 8, 0);
    q = 8 - 1 - (W + 1); // window completed by the last shift before the stall
    n_chk++;
    if (stall_low != 10) $display("FAIL stall_in_ready: in_ready low %0d of 10 stall cycles, want 10", stall_low);
    else n_pass++;
    n_chk++;
    if (stab_err != 0) $display("FAIL hold_stable: %0d held-output changes, want 0", stab_err);
    else n_pass++;
    n_chk++;
    if (st_row != q / W || st_col != q % W || st_mask != model_mask(q / W, q % W, W, H))
      $display("FAIL stall_window: got (%0d,%0d) mask %h, want (%0d,%0d) mask %h",
               st_row, st_col, st_mask, q / W, q % W, model_mask(q / W, q % W, W, H));
    else n_pass++;
    n_chk++;
    if (beat_cyc.size() != N || acc_row.size() != N || done_cyc.size() != 1)
      $display("FAIL bp_counts: beats %0d windows %0d done %0d, want %0d %0d 1",
               beat_cyc.size(), acc_row.size(), done_cyc.size(), N, N);
    else n_pass++;
  endtask

  task automatic test_random_with_start_spam;
    int bad = 0;
    run_frame(2, 2, 0, 1);
    for (int i = 0; i < acc_row.size() && i < N; i++)
      if (acc_row[i] != i / W || acc_col[i] != i % W || acc_mask[i] != model_mask(i / W, i % W, W, H)) bad++;
    n_chk++;
    if (acc_row.size() != N || bad != 0 || done_cyc.size() != 1 || stab_err != 0)
      $display("FAIL random_spam: windows %0d bad %0d done %0d stab %0d, want %0d 0 1 0",
               acc_row.size(), bad, done_cyc.size(), stab_err, N);
    else n_pass++;
    n_chk++;
    if (s_busy !== 1'b0) $display("FAIL spam_restart: busy=%b after frame, want 0", s_busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int k = 0;
    bit seen = 0, got_done = 0;
    int bad = 0;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0; s_in_valid = 1'b1; s_out_ready = 1'b1;
    while (k < 100 && !seen) begin
      @(negedge clk);
      if (s_flush_zero) seen = 1;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    n_chk++;
    if (!seen) $display("FAIL reach_flush: FLUSH not seen within 100 cycles");
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({s_in_ready, s_shift_en, s_flush_zero, s_out_valid, s_busy, s_frame_done} !== 6'b0 ||
        s_out_row !== 7'd0 || s_out_col !== 7'd0 || s_pad_mask !== 9'd0)
      $display("FAIL midreset_outputs: rdy=%b sh=%b fz=%b ov=%b busy=%b fd=%b row=%0d col=%0d mask=%h, want all 0",
               s_in_ready, s_shift_en, s_flush_zero, s_out_valid, s_busy, s_frame_done,
               s_out_row, s_out_col, s_pad_mask);
    else n_pass++;
    repeat (3) begin
      @(negedge clk);
      if (s_frame_done) got_done = 1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (s_frame_done) got_done = 1;
    end
    n_chk++;
    if (got_done) $display("FAIL midreset_done: frame_done pulsed after mid-frame reset, want none");
    else n_pass++;
    @(posedge clk); #1;
    run_frame(2, 2, 0, 0);
    for (int i = 0; i < acc_row.size() && i < N; i++)
      if (acc_row[i] != i / W || acc_col[i] != i % W || acc_mask[i] != model_mask(i / W, i % W, W, H)) bad++;
    n_chk++;
    if (acc_row.size() != N || bad != 0 || done_cyc.size() != 1 || beat_cyc.size() != N)
      $display("FAIL post_reset_frame: windows %0d bad %0d done %0d beats %0d, want %0d 0 1 %0d",
               acc_row.size(), bad, done_cyc.size(), beat_cyc.size(), N, N);
    else n_pass++;
  endtask

  task automatic test_full_size;
    int cnt = 0, bad = 0, dones = 0, cyc = 0, last_r = -1, last_c = -1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b1;
    while (cyc < 40000 && dones == 0) begin
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_start = (cyc < 200) && ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (b_out_valid && b_out_ready) begin
        if (int'(b_out_row) != cnt / BW || int'(b_out_col) != cnt % BW ||
            int'(b_pad_mask) != model_mask(cnt / BW, cnt % BW, BW, BH)) bad++;
        last_r = int'(b_out_row); last_c = int'(b_out_col);
        cnt++;
      end
      if (b_frame_done) dones++;
      @(posedge clk); #1;
      cyc++;
    end
    b_start = 1'b0; b_out_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (b_frame_done) dones++;
      if (b_out_valid) cnt++;
    end
    n_chk++;
    if (cnt != BW * BH) $display("FAIL big_count: got %0d windows, want %0d", cnt, BW * BH);
    else n_pass++;
    n_chk++;
    if (bad != 0 || last_r != BH - 1 || last_c != BW - 1)
      $display("FAIL big_order: %0d bad windows, last (%0d,%0d), want 0 and (%0d,%0d)",
               bad, last_r, last_c, BH - 1, BW - 1);
    else n_pass++;
    n_chk++;
    if (dones != 1 || b_busy !== 1'b0)
      $display("FAIL big_done: %0d frame_done pulses busy=%b, want 1 and 0", dones, b_busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_toggle();
    test_backpressure();
    test_random_with_start_spam();
    test_reset_mid();
    test_full_size();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
